hci_cmd_dispatcher: RTL

//  Sequences the HCI command queue into the I3C bus engine: pops one descriptor, reads its DAT entry,

---
 rtl/hci_cmd_dispatcher.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hci_cmd_dispatcher.sv
// hci_cmd_dispatcher: pops one HCI command, reads its DAT entry, issues one I3C transfer,
// waits for completion and pushes one response. One command in flight at a time.
// Optional watchdog: define I3C_CMD_TIMEOUT_EN to add timeout_limit_i / xfer_abort_o.
module hci_cmd_dispatcher #(
  parameter int unsigned CmdW     = 64,
  parameter int unsigned RespW    = 32,
  parameter int unsigned DatIdxW  = 7,
  parameter int unsigned TimeoutW = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                resume_i,
  input  logic                cmd_fifo_rvalid_i,
  output logic                cmd_fifo_rready_o,
  input  logic [CmdW-1:0]     cmd_fifo_rdata_i,
  output logic                dat_read_valid_o,
  output logic [DatIdxW-1:0]  dat_index_o,
  input  logic [63:0]         dat_rdata_i,
  output logic                xfer_valid_o,
  input  logic                xfer_ready_i,
  output logic [6:0]          xfer_addr_o,
  output logic                xfer_rnw_o,
  output logic [15:0]         xfer_len_o,
  input  logic                xfer_done_i,
  input  logic [3:0]          xfer_err_i,
  input  logic [15:0]         xfer_cnt_i,
  output logic                resp_fifo_wvalid_o,
  input  logic                resp_fifo_wready_i,
  output logic [RespW-1:0]    resp_fifo_wdata_o,
  output logic                busy_o,
`ifdef I3C_CMD_TIMEOUT_EN
  input  logic [TimeoutW-1:0] timeout_limit_i,
  output logic                xfer_abort_o,
`endif
  output logic                halted_o
);

  localparam logic [3:0] ErrBadAttr = 4'h6;
  localparam logic [3:0] ErrTimeout = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DAT_RD, ST_DAT_WAIT, ST_ISSUE, ST_WAIT, ST_RESP
  } state_e;

  state_e             state_q, state_d;
  logic               rready_q, rready_d;
  logic               dat_rd_q, dat_rd_d;
  logic [DatIdxW-1:0] dat_idx_q, dat_idx_d;
  logic               xfer_valid_q, xfer_valid_d;
  logic [6:0]         addr_q, addr_d;
  logic               rnw_q, rnw_d;
  logic [15:0]        len_q, len_d;
  logic [3:0]         tid_q, tid_d;
  logic [3:0]         err_q, err_d;
  logic               wvalid_q, wvalid_d;
  logic [RespW-1:0]   wdata_q, wdata_d;
  logic               busy_q, busy_d;
  logic               halt_q, halt_d;
  logic               halt_set;

  // Descriptor field views
  logic [2:0]         cmd_attr;
  logic [3:0]         cmd_tid;
  logic               cmd_rnw;
  logic [15:0]        cmd_len;
  logic               unused_bits;

  assign cmd_attr    = cmd_fifo_rdata_i[2:0];
  assign cmd_tid     = cmd_fifo_rdata_i[10:7];
  assign cmd_rnw     = cmd_fifo_rdata_i[29];
  assign cmd_len     = cmd_fifo_rdata_i[63:48];
  assign unused_bits = ^{cmd_fifo_rdata_i, dat_rdata_i};

`ifdef I3C_CMD_TIMEOUT_EN
  logic [TimeoutW-1:0] cnt_q, cnt_d, cnt_nxt;
  logic                abort_q, abort_d;
  assign cnt_nxt = cnt_q + TimeoutW'(1);
`else
  localparam int unsigned unused_timeout_w = TimeoutW;
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    rready_d     = 1'b0;
    dat_rd_d     = 1'b0;
    dat_idx_d    = dat_idx_q;
    xfer_valid_d = xfer_valid_q;
    addr_d       = addr_q;
    rnw_d        = rnw_q;
    len_d        = len_q;
    tid_d        = tid_q;
    err_d        = err_q;
    wvalid_d     = wvalid_q;
    wdata_d      = wdata_q;
    halt_set     = 1'b0;
`ifdef I3C_CMD_TIMEOUT_EN
    cnt_d        = cnt_q;
    abort_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable_i && cmd_fifo_rvalid_i && !halt_q) begin
          state_d  = ST_FETCH;
          rready_d = 1'b1;
        end
      end
      ST_FETCH: begin
        tid_d     = cmd_tid;
        rnw_d     = cmd_rnw;
        len_d     = cmd_len;
        dat_idx_d = cmd_fifo_rdata_i[16 +: DatIdxW];
        if (cmd_attr != 3'h0) begin
          // Unsupported attribute: answer without touching DAT or engine
          state_d  = ST_RESP;
          err_d    = ErrBadAttr;
          wvalid_d = 1'b1;
          wdata_d  = RespW'({ErrBadAttr, cmd_tid, 8'h00, 16'h0000});
        end else begin
          state_d  = ST_DAT_RD;
          dat_rd_d = 1'b1;
        end
      end
      ST_DAT_RD: begin
        state_d = ST_DAT_WAIT;
      end
      ST_DAT_WAIT: begin
        addr_d       = dat_rdata_i[6:0];
        state_d      = ST_ISSUE;
        xfer_valid_d = 1'b1;
      end
      ST_ISSUE: begin
        if (xfer_ready_i) begin
          xfer_valid_d = 1'b0;
          state_d      = ST_WAIT;
`ifdef I3C_CMD_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (xfer_done_i) begin
          state_d  = ST_RESP;
          err_d    = xfer_err_i;
          wvalid_d = 1'b1;
          wdata_d  = RespW'({xfer_err_i, tid_q, 8'h00, xfer_cnt_i});
        end
`ifdef I3C_CMD_TIMEOUT_EN
        // Watchdog fires when the count reaches the limit; zero limit disables it
        else if ((timeout_limit_i != '0) && (cnt_nxt == timeout_limit_i)) begin
          state_d  = ST_RESP;
          abort_d  = 1'b1;
          err_d    = ErrTimeout;
          wvalid_d = 1'b1;
          wdata_d  = RespW'({ErrTimeout, tid_q, 8'h00, 16'h0000});
        end else begin
          cnt_d = cnt_nxt;
        end
`endif
      end
      ST_RESP: begin
        if (resp_fifo_wready_i) begin
          wvalid_d = 1'b0;
          state_d  = ST_IDLE;
          halt_set = (err_q != 4'h0);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    // Setting the halt beats a coincident resume
    if (halt_set) begin
      halt_d = 1'b1;
    end else if (resume_i) begin
      halt_d = 1'b0;
    end else begin
      halt_d = halt_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      rready_q     <= 1'b0;
      dat_rd_q     <= 1'b0;
      dat_idx_q    <= '0;
      xfer_valid_q <= 1'b0;
      addr_q       <= '0;
      rnw_q        <= 1'b0;
      len_q        <= '0;
      tid_q        <= '0;
      err_q        <= '0;
      wvalid_q     <= 1'b0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      halt_q       <= 1'b0;
`ifdef I3C_CMD_TIMEOUT_EN
      cnt_q        <= '0;
      abort_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rready_q     <= rready_d;
      dat_rd_q     <= dat_rd_d;
      dat_idx_q    <= dat_idx_d;
      xfer_valid_q <= xfer_valid_d;
      addr_q       <= addr_d;
      rnw_q        <= rnw_d;
      len_q        <= len_d;
      tid_q        <= tid_d;
      err_q        <= err_d;
      wvalid_q     <= wvalid_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      halt_q       <= halt_d;
`ifdef I3C_CMD_TIMEOUT_EN
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
`endif
    end
  end

  assign cmd_fifo_rready_o  = rready_q;
  assign dat_read_valid_o   = dat_rd_q;
  assign dat_index_o        = dat_idx_q;
  assign xfer_valid_o       = xfer_valid_q;
  assign xfer_addr_o        = addr_q;
  assign xfer_rnw_o         = rnw_q;
  assign xfer_len_o         = len_q;
  assign resp_fifo_wvalid_o = wvalid_q;
  assign resp_fifo_wdata_o  = wdata_q;
  assign busy_o             = busy_q;
  assign halted_o           = halt_q;
`ifdef I3C_CMD_TIMEOUT_EN
  assign xfer_abort_o       = abort_q;
`endif

endmodule
